bus_memory: RTL and testbench



---
 rtl/bus_memory.sv | 116 +++++++++++
 tb/tb_bus_memory.sv | 200 ++++++++++++++++++++
 2 files changed

// File: rtl/bus_memory.sv
// Unified instruction/data memory on the core's shared bus.
// Captures a boot image, serves zero-cycle reads and decodes one output and one input register.
module bus_memory #(
  parameter int unsigned          WORD_SIZE   = 16,
  parameter int unsigned          ADDR_SIZE   = 8,
  parameter logic [ADDR_SIZE-1:0] IO_OUT_ADDR = 8'hFC,
  parameter logic [ADDR_SIZE-1:0] IO_IN_ADDR  = 8'hFA
) (
  input  logic                 clk,
  input  logic                 rst,
  inout  wire  [WORD_SIZE-1:0] data_bus,
  input  logic [ADDR_SIZE-1:0] addr_bus,
  input  logic                 wr_en,
  input  logic                 boot,
  input  logic [WORD_SIZE-1:0] boot_data,
  input  logic [WORD_SIZE-1:0] io_in,
  output logic [WORD_SIZE-1:0] io_out,
  output logic [ADDR_SIZE-1:0] boot_words,
  output logic [WORD_SIZE-1:0] boot_sum,
  output logic                 boot_done,
  output logic                 misalign
);

  localparam int unsigned Depth = 2 ** (ADDR_SIZE - 1);

  logic [WORD_SIZE-1:0] mem [Depth];
  logic [ADDR_SIZE-2:0] word_idx;

  logic [WORD_SIZE-1:0] io_out_q, io_out_d;
  logic [WORD_SIZE-1:0] io_in_q;
  logic [ADDR_SIZE-1:0] boot_words_q, boot_words_d;
  logic [WORD_SIZE-1:0] boot_sum_q, boot_sum_d;
  logic                 boot_done_q, boot_done_d;
  logic                 misalign_q, misalign_d;
  logic                 boot_q;

  logic                 boot_wr, run_wr, io_out_hit, mem_wr;
  logic [WORD_SIZE-1:0] mem_wdata;
  logic [WORD_SIZE-1:0] rd_data;

  // Odd addresses alias to their even neighbour.
  assign word_idx   = addr_bus[ADDR_SIZE-1:1];
  assign io_out_hit = (addr_bus == IO_OUT_ADDR);
  assign boot_wr    = ~rst & boot & wr_en;
  assign run_wr     = ~rst & ~boot & wr_en;
  // IO decode applies only in run mode; boot writes always land in the array.
  assign mem_wr     = boot_wr | (run_wr & ~io_out_hit);
  assign mem_wdata  = boot ? boot_data : data_bus;

  always_comb begin
    rd_data = mem[word_idx];
    if (!boot && io_out_hit) begin
      rd_data = io_out_q;
    end else if (!boot && addr_bus == IO_IN_ADDR) begin
      rd_data = io_in_q;
    end
  end

  // Complement of the core's drive condition, so the bus never sees two drivers.
  assign data_bus = wr_en ? {WORD_SIZE{1'bz}} : rd_data;

  always_comb begin
    io_out_d     = io_out_q;
    boot_words_d = boot_words_q;
    boot_sum_d   = boot_sum_q;
    boot_done_d  = boot_done_q;
    misalign_d   = misalign_q;
    if (boot_wr) begin
      boot_words_d = boot_words_q + {{(ADDR_SIZE-1){1'b0}}, 1'b1};
      boot_sum_d   = boot_sum_q + boot_data;
    end
    if (run_wr && io_out_hit) begin
      io_out_d = data_bus;
    end
    if (run_wr && addr_bus[0]) begin
      misalign_d = 1'b1;
    end
    if (boot_q && !boot) begin
      boot_done_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      io_out_q     <= '0;
      io_in_q      <= '0;
      boot_words_q <= '0;
      boot_sum_q   <= '0;
      boot_done_q  <= 1'b0;
      misalign_q   <= 1'b0;
      boot_q       <= 1'b0;
    end else begin
      io_out_q     <= io_out_d;
      io_in_q      <= io_in;
      boot_words_q <= boot_words_d;
      boot_sum_q   <= boot_sum_d;
      boot_done_q  <= boot_done_d;
      misalign_q   <= misalign_d;
      boot_q       <= boot;
    end
  end

  // Array contents survive reset.
  always_ff @(posedge clk) begin
    if (mem_wr) begin
      mem[word_idx] <= mem_wdata;
    end
  end

  assign io_out     = io_out_q;
  assign boot_words = boot_words_q;
  assign boot_sum   = boot_sum_q;
  assign boot_done  = boot_done_q;
  assign misalign   = misalign_q;

endmodule

// File: tb/tb_bus_memory.sv
// Bench for bus_memory: directed boot/IO/misalign/reset scenarios, then random traffic,
// all checked against a word-array reference model.
module tb_bus_memory;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        boot = 1'b0;
  logic        wr_en = 1'b0;
  logic [7:0]  addr_bus = 8'h00;
  logic [15:0] boot_data = 16'h0000;
  logic [15:0] io_in = 16'h0000;
  logic [15:0] tb_bus = 16'h0000;
  logic        tb_drv;
  wire  [15:0] data_bus;
  logic [15:0] io_out, boot_sum;
  logic [7:0]  boot_words;
  logic        boot_done, misalign;

  int n_checks = 0;
  int n_errors = 0;

  // Reference state
  logic [15:0] m_mem [128];
  bit          m_known [128];
  logic [15:0] m_io_out = 0, m_io_in_q = 0;
  int          m_words = 0;
  int          m_sum = 0;
  bit          m_done = 0, m_mis = 0, m_boot_q = 0;

  assign tb_drv   = !boot && wr_en;
  assign data_bus = tb_drv ? tb_bus : 16'hzzzz;

  always #5 clk = ~clk;

  bus_memory dut (
    .clk        (clk),
    .rst        (rst),
    .data_bus   (data_bus),
    .addr_bus   (addr_bus),
    .wr_en      (wr_en),
    .boot       (boot),
    .boot_data  (boot_data),
    .io_in      (io_in),
    .io_out     (io_out),
    .boot_words (boot_words),
    .boot_sum   (boot_sum),
    .boot_done  (boot_done),
    .misalign   (misalign)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic set_in(input bit r, input bit b, input bit w, input logic [7:0] a,
                        input logic [15:0] bd, input logic [15:0] bus);
    rst = r; boot = b; wr_en = w; addr_bus = a; boot_data = bd; tb_bus = bus;
  endtask

  // One clock: check the combinational read, advance the model, check registered outputs.
  task automatic tick();
    int idx;
    #4;
    idx = int'(addr_bus) / 2;
    if (!wr_en) begin
      if (!boot && addr_bus == 8'hFC)      check_eq("rd_io_out", data_bus, m_io_out);
      else if (!boot && addr_bus == 8'hFA) check_eq("rd_io_in", data_bus, m_io_in_q);
      else if (m_known[idx])               check_eq("rd_mem", data_bus, m_mem[idx]);
    end else if (tb_drv) begin
      check_eq("bus_release", data_bus, tb_bus);
    end
    @(posedge clk);
    if (!rst) begin
      if (wr_en && boot) begin
        m_mem[idx] = boot_data; m_known[idx] = 1;
        m_words += 1;
        m_sum = (m_sum + int'(boot_data)) % 65536;
      end else if (wr_en) begin
        if (addr_bus == 8'hFC) m_io_out = tb_bus;
        else begin m_mem[idx] = tb_bus; m_known[idx] = 1; end
        if (addr_bus[0]) m_mis = 1;
      end
      if (m_boot_q && !boot) m_done = 1;
      m_boot_q = boot;
      m_io_in_q = io_in;
    end else begin
      m_io_out = 0; m_io_in_q = 0; m_words = 0; m_sum = 0;
      m_done = 0; m_mis = 0; m_boot_q = 0;
    end
    #1;
    check_eq("io_out", io_out, m_io_out);
    check_eq("boot_words", boot_words, m_words);
    check_eq("boot_sum", boot_sum, m_sum);
    check_eq("boot_done", boot_done, m_done);
    check_eq("misalign", misalign, m_mis);
  endtask

  initial begin
    for (int i = 0; i < 128; i++) m_known[i] = 0;

    // Reset
    set_in(1, 0, 0, 8'h00, 0, 0);
    tick(); tick();
    check_eq("reset_io_out", io_out, 0);
    check_eq("reset_done", boot_done, 0);

    // Full boot load
    for (int a = 0; a < 256; a += 2) begin
      set_in(0, 1, 1, 8'(a), 16'(a) + 16'h1000, 0);
      tick();
    end
    set_in(0, 0, 0, 8'h10, 0, 0);
    #1 check_eq("boot_readback", data_bus, 16'h1010);
    tick();
    check_eq("full_words", boot_words, 8'd128);
    check_eq("full_sum", boot_sum, 16'h3F80);
    check_eq("full_done", boot_done, 1);

    // Combinational read, then bench drives with the memory released
    set_in(0, 0, 0, 8'h20, 0, 0);
    #1 check_eq("comb_read", data_bus, 16'h1020);
    tick();
    set_in(0, 0, 1, 8'h20, 0, 16'h5A5A);
    #1 check_eq("mem_hi_z", data_bus, 16'h5A5A);
    tick();

    // IO output register; array word 126 must be untouched
    set_in(0, 0, 1, 8'hFC, 0, 16'hBEEF);
    tick();
    check_eq("io_out_write", io_out, 16'hBEEF);
    set_in(0, 1, 0, 8'hFC, 0, 0);
    #1 check_eq("word126_kept", data_bus, 16'h10FC);
    tick();
    set_in(0, 0, 0, 8'hFC, 0, 0);
    tick();

    // IO input register
    io_in = 16'h55AA;
    set_in(0, 0, 0, 8'hFA, 0, 0);
    tick(); tick();
    #1 check_eq("io_in_read", data_bus, 16'h55AA);

    // Misaligned write
    set_in(0, 0, 1, 8'h41, 0, 16'h1234);
    tick();
    check_eq("misalign_set", misalign, 1);
    set_in(0, 0, 0, 8'h40, 0, 0);
    #1 check_eq("alias_read", data_bus, 16'h1234);
    tick();
    set_in(0, 0, 1, 8'h42, 0, 16'h4321);
    tick();
    check_eq("misalign_sticky", misalign, 1);

    // Reset mid-boot: 10 words, reset with write levels, then a 4-word reboot
    set_in(1, 0, 0, 8'h00, 0, 0);
    tick();
    for (int i = 0; i < 10; i++) begin
      set_in(0, 1, 1, 8'(2 * i), 16'($urandom), 0);
      tick();
    end
    set_in(1, 1, 1, 8'h60, 16'hDEAD, 0);
    tick();
    for (int i = 0; i < 4; i++) begin
      set_in(0, 1, 1, 8'(8'h80 + 2 * i), 16'h0001, 0);
      tick();
    end
    set_in(0, 0, 0, 8'h60, 0, 0);
    #1 check_eq("rst_blocks_write", data_bus, 16'h1060);
    tick();
    check_eq("reboot_words", boot_words, 8'd4);
    check_eq("reboot_sum", boot_sum, 16'h0004);

    // Boot write to the IO output address hits the array, not io_out
    set_in(0, 1, 1, 8'hFC, 16'hAAAA, 0);
    tick();
    set_in(0, 0, 0, 8'hFC, 0, 0);
    #1 check_eq("boot_io_bypass", data_bus, 16'h0000);
    tick();
    check_eq("io_out_stays", io_out, 0);

    // Random traffic
    for (int c = 0; c < 600; c++) begin
      bit r, b, w;
      r = ($urandom_range(0, 39) == 0);
      b = ($urandom_range(0, 9) < 3) ? ~boot : boot;
      w = $urandom_range(0, 1) == 1;
      io_in = 16'($urandom);
      set_in(r, b, w, 8'($urandom), 16'($urandom), 16'($urandom));
      tick();
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
